// File: rtl/alu_word_seq_if.sv
// Sequencer bus bundle: request/result handshakes plus the W-bit alu word port.
// Optional flag outputs out_z/out_v exist only when ALU_WORD_SEQ_FLAGS_EN is defined.
interface alu_word_seq_if #(
  parameter int W = 4,
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_op;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic [2:0]     alu_mux;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_ci;
  logic [W-1:0]   alu_s;
  logic           alu_co;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_s;
  logic           out_co;
`ifdef ALU_WORD_SEQ_FLAGS_EN
  logic           out_z;
  logic           out_v;
`endif

  modport slave (
    input  in_valid, in_op, in_a, in_b, alu_s, alu_co, out_ready,
    output in_ready, alu_mux, alu_a, alu_b, alu_ci, out_valid, out_s, out_co
`ifdef ALU_WORD_SEQ_FLAGS_EN
    , output out_z, out_v
`endif
  );

  modport master (
    output in_valid, in_op, in_a, in_b, alu_s, alu_co, out_ready,
    input  in_ready, alu_mux, alu_a, alu_b, alu_ci, out_valid, out_s, out_co
`ifdef ALU_WORD_SEQ_FLAGS_EN
    , input out_z, out_v
`endif
  );
endinterface

// File: rtl/alu_word_seq.sv
// Drives a W-bit alu one word per cycle (LSW first) for N*W-bit ops; result valid N cycles
// after accept, held in DONE until out_ready. ALU_WORD_SEQ_FLAGS_EN adds out_z/out_v.
module alu_word_seq #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_word_seq_if.slave bus
);
  localparam int NW = N * W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic [2:0]      op_q;
  logic [NW-1:0]   a_q;
  logic [NW-1:0]   b_q;
  logic [NW-1:0]   s_q;
  logic [NW-1:0]   s_d;
  logic            cy_q;
  logic            co_q;
  logic            arith;
  logic            last_word;
`ifdef ALU_WORD_SEQ_FLAGS_EN
  logic            z_q;
  logic            v_q;
`endif

  assign arith     = (op_q[1:0] == 2'b00);
  assign last_word = (k_q == KW'(N - 1));

  // Result with the current alu word merged in; used both for storage and the zero flag.
  always_comb begin
    s_d = s_q;
    s_d[k_q*W +: W] = bus.alu_s;
  end

  always_comb begin
    bus.alu_mux = 3'b000;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_ci  = 1'b0;
    if (state_q == RUN) begin
      bus.alu_mux = op_q;
      bus.alu_a   = a_q[k_q*W +: W];
      bus.alu_b   = b_q[k_q*W +: W];
      bus.alu_ci  = (k_q == '0) ? op_q[2] : (arith & cy_q);
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_s     = s_q;
  assign bus.out_co    = co_q;
`ifdef ALU_WORD_SEQ_FLAGS_EN
  assign bus.out_z     = z_q;
  assign bus.out_v     = v_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
`ifdef ALU_WORD_SEQ_FLAGS_EN
      z_q     <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q    <= bus.in_op;
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q  <= s_d;
          cy_q <= bus.alu_co;
          if (last_word) begin
            k_q     <= '0;
            co_q    <= arith & bus.alu_co;
`ifdef ALU_WORD_SEQ_FLAGS_EN
            z_q     <= (s_d == '0);
            // Sub overflows against ~b, so the effective b msb is flipped by op[2].
            v_q     <= arith & (a_q[NW-1] ^ bus.alu_s[W-1])
                             & ((b_q[NW-1] ^ op_q[2]) ^ bus.alu_s[W-1]);
`endif
            state_q <= DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_word_seq.sv
// Directed bench for alu_word_seq (W=4, N=4) with a behavioural model of the W-bit alu.
module tb_alu_word_seq;
  localparam int W = 4;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [W:0] alu_r;

  alu_word_seq_if #(.W(W), .N(N)) sif ();

  alu_word_seq #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference W-bit alu sitting behind the sequencer.
  always_comb begin
    alu_r = '0;
    case (sif.alu_mux)
      3'b000: alu_r = {1'b0, sif.alu_a} + {1'b0, sif.alu_b} + {{W{1'b0}}, sif.alu_ci};
      3'b100: alu_r = {1'b0, sif.alu_a} + {1'b0, ~sif.alu_b} + {{W{1'b0}}, sif.alu_ci};
      3'b001: alu_r = {1'b0, sif.alu_a & sif.alu_b};
      3'b010: alu_r = {1'b0, sif.alu_a | sif.alu_b};
      3'b011: alu_r = {1'b0, sif.alu_a ^ sif.alu_b};
      default: alu_r = '0;
    endcase
    sif.alu_s  = alu_r[W-1:0];
    sif.alu_co = alu_r[W];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after the accept edge; walks the N RUN cycles and checks the DONE result.
  task automatic finish_op(input string tag, input logic [15:0] es, input logic ec,
                           input logic [3:0] eci, input logic [2:0] eop,
                           input logic ez, input logic ev);
    logic [3:0] ci;
    logic       early;
    ci    = '0;
    early = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i == 0) check({tag, "_mux"}, 64'(sif.alu_mux), 64'(eop));
      ci[i] = sif.alu_ci;
      early = early | sif.out_valid;
    end
    check({tag, "_early_valid"}, 64'(early), 64'd0);
    check({tag, "_ci_seq"}, 64'(ci), 64'(eci));
    @(negedge clk);
    check({tag, "_valid"}, 64'(sif.out_valid), 64'd1);
    check({tag, "_s"}, 64'(sif.out_s), 64'(es));
    check({tag, "_co"}, 64'(sif.out_co), 64'(ec));
`ifdef ALU_WORD_SEQ_FLAGS_EN
    check({tag, "_z"}, 64'(sif.out_z), 64'(ez));
    check({tag, "_v"}, 64'(sif.out_v), 64'(ev));
`else
    if (ez === 1'bx || ev === 1'bx) $display("note: unknown flag expectation for %s", tag);
`endif
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] es, input logic ec,
                        input logic [3:0] eci, input logic ez, input logic ev);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(sif.in_ready), 64'd1);
    sif.in_valid = 1'b1;
    sif.in_op    = op;
    sif.in_a     = a;
    sif.in_b     = b;
    @(posedge clk);
    #1;
    // Scramble the request inputs: the sequencer must use its captured copy.
    sif.in_valid = 1'b0;
    sif.in_op    = 3'b011;
    sif.in_a     = ~a;
    sif.in_b     = ~b;
    finish_op(tag, es, ec, eci, op, ez, ev);
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, 64'(sif.out_valid), 64'd0);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    sif.in_valid  = 1'b0;
    sif.in_op     = 3'b000;
    sif.in_a      = '0;
    sif.in_b      = '0;
    sif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(sif.in_ready), 64'd1);
    check("rst_out_valid", 64'(sif.out_valid), 64'd0);
    check("rst_out_s", 64'(sif.out_s), 64'd0);
    check("rst_out_co", 64'(sif.out_co), 64'd0);
    check("rst_alu_mux", 64'(sif.alu_mux), 64'd0);
    rst_n = 1'b1;

    run_op("add_carry4",   3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 4'b0110, 1'b0, 1'b0);
    run_op("add_wrap",     3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4'b1110, 1'b1, 1'b0);
    run_op("sub_borrow3",  3'b100, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 4'b0001, 1'b0, 1'b0);
    run_op("sub_neg",      3'b100, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 4'b0001, 1'b0, 1'b0);
    run_op("xor",          3'b011, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_op("and",          3'b001, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_op("or",           3'b010, 16'h1200, 16'h0034, 16'h1234, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Backpressure in DONE with a new request waiting.
    sif.out_ready = 1'b0;
    @(negedge clk);
    sif.in_valid = 1'b1;
    sif.in_op    = 3'b011;
    sif.in_a     = 16'hA5A5;
    sif.in_b     = 16'hA5A5;
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    finish_op("bp_xor", 16'h0000, 1'b0, 4'b0000, 3'b011, 1'b1, 1'b0);
    sif.in_valid = 1'b1;
    sif.in_op    = 3'b000;
    sif.in_a     = 16'h1111;
    sif.in_b     = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(sif.out_valid), 64'd1);
      check("bp_hold_s", 64'(sif.out_s), 64'h0000);
      check("bp_hold_co", 64'(sif.out_co), 64'd0);
      check("bp_hold_in_ready", 64'(sif.in_ready), 64'd0);
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(sif.out_valid), 64'd0);
    check("bp_release_in_ready", 64'(sif.in_ready), 64'd1);
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    finish_op("bp_pending", 16'h3333, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0);

    // Reset in the middle of RUN at word 2.
    @(negedge clk);
    sif.in_valid = 1'b1;
    sif.in_op    = 3'b000;
    sif.in_a     = 16'hFFFF;
    sif.in_b     = 16'h0001;
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_k2_alu_a", 64'(sif.alu_a), 64'hF);
    check("mid_k2_alu_ci", 64'(sif.alu_ci), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", 64'(sif.in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(sif.out_valid), 64'd0);
    check("mid_rst_out_s", 64'(sif.out_s), 64'd0);
    check("mid_rst_alu", 64'({sif.alu_mux, sif.alu_a, sif.alu_b, sif.alu_ci}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_after_rst", 3'b000, 16'h0003, 16'h0004, 16'h0007, 1'b0, 4'b0000, 1'b0, 1'b0);

`ifdef ALU_WORD_SEQ_FLAGS_EN
    run_op("flag_ovf", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 4'b1110, 1'b0, 1'b1);
    run_op("flag_zero", 3'b100, 16'h1234, 16'h1234, 16'h0000, 1'b1, 4'b1111, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_word_seq.md
Name: alu_word_seq

Overview:
- Multi-word operation sequencer placed directly in front of the W-bit combinational alu.
- Accepts one N*W-bit operation per handshake and drives the alu one W-bit word per cycle, least significant word first.
- Chains carry between words, collects the result words and returns the full-width result and carry-out through a valid/ready output.
- Lets the narrow alu serve wide add/sub/and/or/xor.

Parameters:
- W, 4, alu word width in bits; must match the alu instance's W.
- N, 4, number of words per operand (N >= 1); operand width is N*W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operation request valid.
- in_ready  out  1  sequencer can accept a request.
- in_op  in  3  operation code, same encoding as the alu mux: 000 add, 100 sub, 001 and, 010 or, 011 xor.
- in_a  in  N*W  operand a.
- in_b  in  N*W  operand b.
- alu_mux  out  3  to alu mux.
- alu_a  out  W  to alu a.
- alu_b  out  W  to alu b.
- alu_ci  out  1  to alu ci.
- alu_s  in  W  alu sum/result, combinational from alu_mux/a/b/ci.
- alu_co  in  1  alu carry-out; for sub this is a + ~b + ci carry, 1 = no borrow.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_s  out  N*W  full result.
- out_co  out  1  final carry-out; 0 for logic ops.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, in_ready=1, out_valid=0, out_s=0, out_co=0, alu_mux=0, alu_a=0, alu_b=0, alu_ci=0, word index k=0. Reset overrides everything, including mid-RUN or DONE; any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch in_op, in_a and in_b, set k=0, go to RUN.
  - No other input has effect.
- RUN:
  - in_ready=0.
  - Combinationally drive alu_mux=op, alu_a=a[k*W +: W], alu_b=b[k*W +: W].
  - alu_ci: word 0 uses op[2] (0 for add, 1 for sub). Words k>0 use the registered carry from word k-1 for arithmetic ops (op[1:0]=00), and 0 for logic ops.
  - Each cycle, register alu_s into out_s[k*W +: W] and alu_co into the carry register, then increment k.
  - After word N-1, go to DONE.
- DONE:
  - out_valid=1.
  - out_co = final carry for arithmetic ops, 0 for logic ops.
  - out_s and out_co stay stable until out_ready=1; on that edge go to IDLE.
  - in_valid is ignored in DONE; there is no bypass from DONE to RUN.
- Outside RUN, alu_* outputs are 0.
- Latency: request accepted at edge t; words processed in the cycles following edges t..t+N-1; out_valid high from edge t+N. Minimum spacing between accepts is N+2 cycles with out_ready tied high.
- N=1: a single RUN cycle; alu_ci = op[2].
- Undefined op codes (101, 110, 111) are passed through to the alu unchanged. Carry rules follow op[2] and op[1:0] as above; the result is whatever the alu yields.
- Operands are captured at accept; changes on in_a, in_b or in_op afterwards have no effect.
- out_s holds the last result after the DONE→IDLE transition until overwritten word-by-word by the next operation.

Optional Feature:
- Macro: ALU_WORD_SEQ_FLAGS_EN.
- Defined: adds outputs out_z (1 bit) and out_v (1 bit), both valid with out_valid and reset to 0.
  - out_z=1 when out_s is all zeros.
  - out_v = signed overflow for add/sub: (a_msb ^ s_msb) & (beff_msb ^ s_msb), where beff = b for add and ~b for sub. out_v=0 for logic ops.
  - Both are registered at the DONE transition.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- add 0x00FF + 0x0001 (W=4, N=4), out_ready=1 -> out_s=0x0100, out_co=0; out_valid exactly N cycles after the accept edge, high for one cycle; alu_ci sequence 0,1,1,0.
- add 0xFFFF + 0x0001 -> out_s=0x0000, out_co=1. sub 0x1000 - 0x0001 -> 0x0FFF, out_co=1. sub 0x0000 - 0x0001 -> 0xFFFF, out_co=0.
- xor 0xA5A5 ^ 0xFFFF -> 0x5A5A; and 0xF0F0 & 0x3C3C -> 0x3030; or 0x1200 | 0x0034 -> 0x1234; out_co=0 and alu_ci=0 for every word of all three.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> out_s/out_co stable, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle, then the pending request is accepted.
- Reset mid-operation: assert rst_n=0 during RUN at k=2 -> after that edge in_ready=1, out_valid=0, out_s=0, alu_*=0. The next add 0x0003 + 0x0004 yields 0x0007.
- FLAGS_EN: add 0x7FFF + 0x0001 -> out_v=1, out_z=0. sub 0x1234 - 0x1234 -> out_z=1, out_v=0, out_co=1.
